ysyx_23060124_reg_writeback: RTL and testbench
==============================================

YSYX_23060124_REG_WRITEBACK -- requirements
Module: ysyx_23060124_reg_writeback

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1 / in_ready  output  1  result handshake from execute stage.
REQ-004 SHALL have ports: in_rd  input  4  destination register; in_wen  input  1  result writes a register.
REQ-005 SHALL have ports: in_wdata  input  32  ALU/CSR result; in_is_load  input  1  result arrives from LSU instead.
REQ-006 SHALL have ports: in_funct3  input  3  load type; in_addr_lo  input  2  load byte offset.
REQ-007 SHALL have ports: lsu_rvalid  input  1 / lsu_rready  output  1 / lsu_rdata  input  32 / lsu_rresp  input  2  (nonzero = error).
REQ-008 SHALL have ports: rf_wen  output  1 / rf_waddr  output  4 / rf_wdata  output  32  register file write port.
REQ-009 SHALL have port: wbu_rd  output  4  pending destination for hazard check; 0 when nothing pending.
REQ-010 SHALL have ports: commit_valid  output  1  one-cycle retire pulse; load_err  output  1  one-cycle error pulse.

Function
REQ-011 SHALL implement states IDLE, LOAD_WAIT, COMMIT.
REQ-012 in_ready SHALL be 1 in IDLE and COMMIT, 0 in LOAD_WAIT.
REQ-013 Accept on in_valid && in_ready: capture rd, wen, wdata, is_load, funct3, addr_lo; next state LOAD_WAIT if in_is_load, else COMMIT.
REQ-014 In COMMIT with no accept, next state SHALL be IDLE; with accept, per REQ-013 (back-to-back, one result per cycle).
REQ-015 lsu_rready SHALL be 1 only in LOAD_WAIT; lsu_rvalid outside LOAD_WAIT SHALL be ignored.
REQ-016 In LOAD_WAIT on lsu_rvalid: capture extended load data and error flag (lsu_rresp != 0); next state COMMIT.
REQ-017 Load extension: funct3 000 LB sign-extend byte addr_lo; 001 LH sign-extend half addr_lo[1]; 100 LBU / 101 LHU zero-extend; 010 and all others full word.
REQ-018 In COMMIT: rf_wen = captured wen && rd != 0 && !error; rf_waddr = captured rd; rf_wdata = captured data; all else rf_wen = 0.
REQ-019 rf_waddr and rf_wdata SHALL be 0 whenever rf_wen = 0.
REQ-020 commit_valid SHALL be 1 exactly in each COMMIT cycle; load_err SHALL be 1 in COMMIT only when captured error set.
REQ-021 Latency: non-load accepted cycle N -> rf_wen cycle N+1; load rvalid cycle M -> rf_wen cycle M+1.
REQ-022 wbu_rd SHALL equal captured rd while state is LOAD_WAIT or COMMIT and captured wen = 1, else 0.
REQ-023 Errored load SHALL still retire (commit_valid = 1) with no register write.
REQ-024 Accept in COMMIT SHALL overwrite capture registers only after the current commit outputs are driven in that cycle.

Reset
REQ-025 reset SHALL force state IDLE, clear all capture registers; all outputs 0 except in_ready = 1 in the cycle after reset.
REQ-026 reset asserted in LOAD_WAIT or COMMIT SHALL abort the pending result: no rf_wen, commit_valid or load_err afterwards.
REQ-027 reset SHALL override simultaneous in_valid or lsu_rvalid.

Verification
REQ-028 ALU: in_rd=5, in_wen=1, in_wdata=0x12345678 accepted cycle 1 -> cycle 2 rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, commit_valid=1, wbu_rd=5.
REQ-029 LB: funct3=000, addr_lo=2, rd=3; lsu_rdata=0x00800000 after 3 waits -> in_ready=0 during wait, wbu_rd=3, then rf_wdata=0xFFFFFF80.
REQ-030 LHU: funct3=101, addr_lo=2, rdata=0xBEEF0000 -> rf_wdata=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-031 rd=0, wen=1, wdata=0xFFFFFFFF -> commit_valid=1, rf_wen=0, wbu_rd=0.
REQ-032 Load with lsu_rresp=2 -> commit_valid=1, load_err=1, rf_wen=0; back-to-back ALU results rd=1,2,3 on consecutive cycles -> three consecutive rf_wen pulses in order.
REQ-033 reset asserted during LOAD_WAIT, rvalid next cycle -> no rf_wen, no commit_valid, in_ready=1.

Source files
------------

// File: rtl/ysyx_23060124_reg_writeback.sv
// Writeback stage: takes one result per cycle from execute, waits for LSU data on loads,
// extends it by load type and drives a single register-file write plus a retire pulse.
module ysyx_23060124_reg_writeback (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rd,
    input  logic        in_wen,
    input  logic [31:0] in_wdata,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        lsu_rvalid,
    output logic        lsu_rready,
    input  logic [31:0] lsu_rdata,
    input  logic [1:0]  lsu_rresp,
    output logic        rf_wen,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  wbu_rd,
    output logic        commit_valid,
    output logic        load_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_WAIT = 2'd1,
        S_COMMIT    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [31:0] data_q, data_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        err_q, err_d;
    logic        accept;

    function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = rdata;
        endcase
    endfunction

    assign in_ready = (state_q != S_LOAD_WAIT);
    assign accept   = in_valid && in_ready;
    assign wbu_rd   = ((state_q != S_IDLE) && wen_q) ? rd_q : 4'd0;

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wen_d        = wen_q;
        data_d       = data_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        err_d        = err_q;
        lsu_rready   = 1'b0;
        rf_wen       = 1'b0;
        rf_waddr     = 4'd0;
        rf_wdata     = 32'd0;
        commit_valid = 1'b0;
        load_err     = 1'b0;

        case (state_q)
            S_LOAD_WAIT: begin
                lsu_rready = 1'b1;
                if (lsu_rvalid) begin
                    data_d  = load_ext(lsu_rdata, funct3_q, addr_lo_q);
                    err_d   = |lsu_rresp;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit_valid = 1'b1;
                load_err     = err_q;
                if (wen_q && (rd_q != 4'd0) && !err_q) begin
                    rf_wen   = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = data_q;
                end
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // Commit outputs above come from the old capture; a new accept only lands at the edge.
        if (accept) begin
            rd_d      = in_rd;
            wen_d     = in_wen;
            data_d    = in_wdata;
            is_load_d = in_is_load;
            funct3_d  = in_funct3;
            addr_lo_d = in_addr_lo;
            err_d     = 1'b0;
            state_d   = in_is_load ? S_LOAD_WAIT : S_COMMIT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_q      <= 4'd0;
            wen_q     <= 1'b0;
            data_q    <= 32'd0;
            is_load_q <= 1'b0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            data_q    <= data_d;
            is_load_q <= is_load_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_reg_writeback.sv
// Bench for the writeback stage: directed scenarios plus random traffic, all checked
// against a transaction-level model of outstanding loads and due commits.
module tb_ysyx_23060124_reg_writeback;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_wdata;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  wbu_rd;
    logic        commit_valid;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    // Model: an outstanding load (waiting for LSU) and/or a commit due this cycle.
    bit          m_out;
    logic [3:0]  m_o_rd;
    bit          m_o_wen;
    logic [2:0]  m_o_f3;
    logic [1:0]  m_o_off;
    bit          m_com;
    logic [3:0]  m_c_rd;
    bit          m_c_wen;
    logic [31:0] m_c_data;
    bit          m_c_err;

    ysyx_23060124_reg_writeback dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .in_wdata     (in_wdata),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rready   (lsu_rready),
        .lsu_rdata    (lsu_rdata),
        .lsu_rresp    (lsu_rresp),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .wbu_rd       (wbu_rd),
        .commit_valid (commit_valid),
        .load_err     (load_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] rdata, input logic [2:0] f3,
                                            input logic [1:0] off);
        int unsigned b;
        int unsigned h;
        b = (rdata >> (8 * int'(off))) & 32'hFF;
        h = (rdata >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    task automatic model_edge();
        bit was_out;
        was_out = m_out;
        if (reset) begin
            m_out = 0;
            m_com = 0;
        end else if (was_out && lsu_rvalid) begin
            m_out    = 0;
            m_com    = 1;
            m_c_rd   = m_o_rd;
            m_c_wen  = m_o_wen;
            m_c_data = ref_ext(lsu_rdata, m_o_f3, m_o_off);
            m_c_err  = (lsu_rresp != 2'd0);
        end else if (!was_out && in_valid) begin
            if (in_is_load) begin
                m_out   = 1;
                m_com   = 0;
                m_o_rd  = in_rd;
                m_o_wen = in_wen;
                m_o_f3  = in_funct3;
                m_o_off = in_addr_lo;
            end else begin
                m_com    = 1;
                m_c_rd   = in_rd;
                m_c_wen  = in_wen;
                m_c_data = in_wdata;
                m_c_err  = 0;
            end
        end else begin
            m_com = 0;
        end
    endtask

    task automatic check_all();
        bit          e_wen;
        logic [3:0]  e_wbu;
        e_wen = m_com && m_c_wen && (m_c_rd != 0) && !m_c_err;
        if (m_out)      e_wbu = m_o_wen ? m_o_rd : 4'd0;
        else if (m_com) e_wbu = m_c_wen ? m_c_rd : 4'd0;
        else            e_wbu = 4'd0;
        chk("in_ready",     in_ready,     !m_out);
        chk("lsu_rready",   lsu_rready,   m_out);
        chk("commit_valid", commit_valid, m_com);
        chk("load_err",     load_err,     m_com && m_c_err);
        chk("rf_wen",       rf_wen,       e_wen);
        chk("rf_waddr",     rf_waddr,     e_wen ? m_c_rd : 4'd0);
        chk("rf_wdata",     rf_wdata,     e_wen ? m_c_data : 32'd0);
        chk("wbu_rd",       wbu_rd,       e_wbu);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic do_alu(input logic [3:0] rd, input logic wen, input logic [31:0] data);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = rd;
        in_wen     = wen;
        in_wdata   = data;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] rdata, input logic [1:0] resp, input int waits);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = rd;
        in_wen     = 1'b1;
        in_wdata   = 32'hDEAD_0000;
        in_funct3  = f3;
        in_addr_lo = off;
        step();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        chk("ld_wait_ready", in_ready, 1'b0);
        chk("ld_wait_wbu", wbu_rd, rd);
        repeat (waits) step();
        lsu_rvalid = 1'b1;
        lsu_rdata  = rdata;
        lsu_rresp  = resp;
        step();
        lsu_rvalid = 1'b0;
        lsu_rresp  = 2'd0;
    endtask

    initial begin
        m_out = 0; m_com = 0;
        m_o_rd = 0; m_o_wen = 0; m_o_f3 = 0; m_o_off = 0;
        m_c_rd = 0; m_c_wen = 0; m_c_data = 0; m_c_err = 0;
        reset = 1'b1; in_valid = 1'b0; in_rd = 4'd0; in_wen = 1'b0; in_wdata = 32'd0;
        in_is_load = 1'b0; in_funct3 = 3'd0; in_addr_lo = 2'd0;
        lsu_rvalid = 1'b0; lsu_rdata = 32'd0; lsu_rresp = 2'd0;
        @(negedge clock);
        step();
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_commit", commit_valid, 1'b0);
        reset = 1'b0;
        step();

        do_alu(4'd5, 1'b1, 32'h1234_5678);
        chk("alu_wen", rf_wen, 1'b1);
        chk("alu_waddr", rf_waddr, 4'd5);
        chk("alu_wdata", rf_wdata, 32'h1234_5678);
        chk("alu_wbu", wbu_rd, 4'd5);
        step();

        do_load(4'd3, 3'b000, 2'd2, 32'h0080_0000, 2'd0, 3);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        step();
        do_load(4'd4, 3'b101, 2'd2, 32'hBEEF_0000, 2'd0, 1);
        chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);
        do_load(4'd4, 3'b001, 2'd2, 32'hBEEF_0000, 2'd0, 0);
        chk("lh_wdata", rf_wdata, 32'hFFFF_BEEF);
        step();

        do_alu(4'd0, 1'b1, 32'hFFFF_FFFF);
        chk("x0_commit", commit_valid, 1'b1);
        chk("x0_wen", rf_wen, 1'b0);
        chk("x0_wbu", wbu_rd, 4'd0);
        step();

        do_load(4'd7, 3'b010, 2'd0, 32'hCAFE_F00D, 2'd2, 2);
        chk("err_commit", commit_valid, 1'b1);
        chk("err_flag", load_err, 1'b1);
        chk("err_wen", rf_wen, 1'b0);
        step();

        for (int k = 1; k <= 3; k++) begin
            in_valid   = 1'b1;
            in_is_load = 1'b0;
            in_rd      = 4'(k);
            in_wen     = 1'b1;
            in_wdata   = 32'h100 + 32'(k);
            step();
            chk("b2b_wen", rf_wen, 1'b1);
            chk("b2b_waddr", rf_waddr, 4'(k));
        end
        in_valid = 1'b0;
        step();

        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 4'd9; in_wen = 1'b1; in_funct3 = 3'd2;
        step();
        in_valid = 1'b0; in_is_load = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h1111_2222;
        step();
        lsu_rvalid = 1'b0;
        chk("abort_commit", commit_valid, 1'b0);
        chk("abort_wen", rf_wen, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        step();

        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) < 2);
            in_valid   = $urandom_range(0, 1);
            in_is_load = ($urandom_range(0, 9) < 4);
            in_rd      = 4'($urandom_range(0, 15));
            in_wen     = ($urandom_range(0, 9) < 8);
            in_wdata   = $urandom;
            in_funct3  = 3'($urandom_range(0, 7));
            in_addr_lo = 2'($urandom_range(0, 3));
            lsu_rvalid = ($urandom_range(0, 9) < 4);
            lsu_rdata  = $urandom;
            lsu_rresp  = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'd0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
